crc32_frame_check: RTL

- Streaming receive-side frame checker for word-framed links.
- Accepts 32-bit words over valid/ready. Every word except the last feeds a CRC-32 accumulator (poly 0x04C11DB7, MSB-first, one 32-bit word per cycle). The last word of each frame is the transmitted CRC trailer.
- Compares the final CRC against the trailer and emits one status record per frame on a valid/ready result port.
- Sits downstream of the link deframer and upstream of packet-buffer commit logic.

---
 rtl/crc32_pkg.sv | 26 ++
 rtl/crc32_frame_check_crc32_32.sv | 24 ++
 rtl/crc32_frame_check.sv | 125 ++++++++++++
 3 files changed

// File: rtl/crc32_pkg.sv
// Shared definitions for the CRC-32 frame checker: polynomial, default
// INIT/XOROUT values, FSM state encoding and the per-frame status record.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY           = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT_DEFAULT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT_DEFAULT = 32'hFFFFFFFF;

   // Width of the words field in the status record; the frame counter
   // width of the checker must not exceed it.
   localparam int CRC32_WORDS_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BODY = 2'd1,
      HOLD = 2'd2
   } crc32_state_t;

   typedef struct packed {
      logic                     ok;
      logic                     len_err;
      logic [31:0]              crc;
      logic [CRC32_WORDS_W-1:0] words;
   } crc32_status_t;

endpackage

// File: rtl/crc32_frame_check_crc32_32.sv
// CRC-32 combinational update of one 32-bit word, MSB (bit 31) first,
// non-reflected, using the shared polynomial.
module crc32_32
   import crc32_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [31:0] data_i,
   output logic [31:0] crc_o
);

   // Bit-serial LFSR unrolled over the 32 data bits, bit 31 first.
   always_comb begin
      logic [31:0] c;
      logic        fb;
      c  = crc_i;
      fb = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ data_i[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
      end
      crc_o = c;
   end

endmodule

// File: rtl/crc32_frame_check.sv
// Receive-side frame checker: accumulates CRC-32 over every word of a frame
// except the last, compares the result (after XOROUT) against the trailer
// word and presents one status record per frame on a valid/ready port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; valid, once raised, holds its payload stable until
// that edge, and ready never depends combinationally on valid.
//
// CNT_W may be at most CRC32_WORDS_W (16).
module crc32_frame_check
   import crc32_pkg::*;
#(
   parameter logic [31:0] INIT   = CRC32_INIT_DEFAULT,
   parameter logic [31:0] XOROUT = CRC32_XOROUT_DEFAULT,
   parameter int          CNT_W  = 16
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic [31:0]      s_data_i,
   input  logic             s_last_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic             res_ok_o,
   output logic             res_len_err_o,
   output logic [31:0]      res_crc_o,
   output logic [CNT_W-1:0] res_words_o
);

   crc32_state_t  state;
   crc32_state_t  state_n;
   logic [31:0]   crc_reg;
   logic [31:0]   crc_next;
   logic [31:0]   step_in;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   crc32_status_t res_q;
   logic          accept;
   logic [31:0]   crc_final;

   // clear_i wins over the input handshake: a word offered alongside it is dropped.
   assign accept    = s_valid_i && s_ready_o && !clear_i;
   assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
   assign crc_final = crc_reg ^ XOROUT;
   assign step_in   = (state == IDLE) ? INIT : crc_reg;

   crc32_32 u_step (
      .crc_i  (step_in),
      .data_i (s_data_i),
      .crc_o  (crc_next)
   );

   // Next-state decode: the frame ends on the trailer, the record is held until consumed.
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept) state_n = s_last_i ? HOLD : BODY;
         BODY: if (accept && s_last_i) state_n = HOLD;
         HOLD: if (res_ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (clear_i) state_n = IDLE;
   end

   // State register plus registered decodes of the next state for the two handshake outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         s_ready_o   <= 1'b1;
         res_valid_o <= 1'b0;
      end else begin
         state       <= state_n;
         s_ready_o   <= (state_n != HOLD);
         res_valid_o <= (state_n == HOLD);
      end
   end

   // CRC accumulator, saturating word counter and the status record.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_reg <= INIT;
         count   <= '0;
         res_q   <= '0;
      end else if (clear_i) begin
         crc_reg <= INIT;
         count   <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            if (s_last_i) begin
               // Trailer with no body: nothing was checked.
               res_q.ok      <= 1'b0;
               res_q.len_err <= 1'b1;
               res_q.crc     <= INIT ^ XOROUT;
               res_q.words   <= CRC32_WORDS_W'(1);
               crc_reg       <= INIT;
               count         <= '0;
            end else begin
               crc_reg <= crc_next;
               count   <= CNT_W'(1);
            end
         end else if (state == BODY) begin
            if (s_last_i) begin
               // The trailer itself is never folded into the CRC.
               res_q.ok      <= (crc_final == s_data_i);
               res_q.len_err <= 1'b0;
               res_q.crc     <= crc_final;
               res_q.words   <= CRC32_WORDS_W'(count_inc);
               crc_reg       <= INIT;
               count         <= '0;
            end else begin
               crc_reg <= crc_next;
               count   <= count_inc;
            end
         end
      end
   end

   assign res_ok_o      = res_q.ok;
   assign res_len_err_o = res_q.len_err;
   assign res_crc_o     = res_q.crc;
   assign res_words_o   = res_q.words[CNT_W-1:0];

endmodule
